// File: rtl/infac_pkg.sv
// Shared types and constants for the factorial-base numeral parser.
package infac_pkg;

    localparam int unsigned MAXDIG     = 12;
    localparam int unsigned CNT_W      = $clog2(MAXDIG + 1);
    localparam logic [7:0]  ASCII_ZERO = 8'h30;
    localparam logic [7:0]  ASCII_LAST = ASCII_ZERO + 8'(MAXDIG - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSkip,
        StCompute,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsDigit,
        ClsDelim,
        ClsOther
    } byte_cls_e;

    // Delimiter match wins over digit match so callers may pick any terminator.
    function automatic byte_cls_e classify(input logic [7:0] b, input logic [7:0] d1,
                                           input logic [7:0] d2);
        if ((b == d1) || (b == d2)) begin
            return ClsDelim;
        end
        if ((b >= ASCII_ZERO) && (b <= ASCII_LAST)) begin
            return ClsDigit;
        end
        return ClsOther;
    endfunction

endpackage

// File: rtl/infac_with_delims_if.sv
// Caller-facing handshake: start/result/result_ready plus the UART byte stream.
interface infac_with_delims_if #(
    parameter int unsigned W = 22
) ();

    logic         start;
    logic [7:0]   inbyte;
    logic         inbyte_valid;
    logic [7:0]   delim1byte;
    logic [7:0]   delim2byte;
    logic [W-1:0] result;
    logic         result_err;
    logic         result_ready;

    modport slave (
        input  start, inbyte, inbyte_valid, delim1byte, delim2byte,
        output result, result_err, result_ready
    );

    modport master (
        output start, inbyte, inbyte_valid, delim1byte, delim2byte,
        input  result, result_err, result_ready
    );

endinterface

// File: rtl/infac_digit_buffer.sv
// Holds received factorial-base digits in arrival order with an indexed read port.
module infac_digit_buffer
    import infac_pkg::*;
#(
    parameter int unsigned Depth = MAXDIG,
    parameter int unsigned CntW  = CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [3:0]      data_i,
    input  logic [CntW-1:0] rd_idx_i,
    output logic [3:0]      rd_data_o,
    output logic [CntW-1:0] count_o
);

    logic [3:0]      mem_q [Depth];
    logic [CntW-1:0] count_q;

    // Storage needs no reset: only indices below count_q are ever read.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (push_i && (count_q < CntW'(Depth))) begin
            mem_q[count_q] <= data_i;
            count_q        <= count_q + 1'b1;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign count_o   = count_q;

endmodule

// File: rtl/infac_with_delims.sv
// Parses a delimiter-terminated factorial-base ASCII numeral into a W-bit integer.
module infac_with_delims
    import infac_pkg::*;
#(
    parameter int unsigned W = 22
) (
    input  logic                clk,
    input  logic                rst,
    infac_with_delims_if.slave  bus_io
);

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic [CNT_W-1:0] j_q, j_d;
    logic            cerr_q, cerr_d;
    logic            result_err_q, result_err_d;

    logic            buf_push, buf_clear;
    logic [CNT_W-1:0] buf_count, rd_idx;
    logic [3:0]      rd_data, in_digit;
    byte_cls_e       in_cls;
    logic [W+3:0]    sum_w, prod_w;
    logic            dig_err, ovf_err, step_err;

    infac_digit_buffer #(
        .Depth (MAXDIG),
        .CntW  (CNT_W)
    ) u_digits (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (buf_clear),
        .push_i    (buf_push),
        .data_i    (in_digit),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .count_o   (buf_count)
    );

    assign in_cls   = classify(bus_io.inbyte, bus_io.delim1byte, bus_io.delim2byte);
    assign in_digit = 4'(bus_io.inbyte - ASCII_ZERO);

    // First-received digit carries the highest weight, so it sits at index count-j.
    assign rd_idx   = buf_count - j_q;
    assign sum_w    = {4'b0000, acc_q} + {{W{1'b0}}, rd_data};
    assign prod_w   = sum_w * {{(W + 4 - CNT_W){1'b0}}, j_q};
    assign dig_err  = (CNT_W'(rd_data) > j_q);
    assign ovf_err  = |prod_w[W+3:W];
    assign step_err = dig_err | ovf_err;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        j_d          = j_q;
        cerr_d       = cerr_q;
        result_d     = result_q;
        result_err_d = result_err_q;
        buf_push     = 1'b0;
        buf_clear    = 1'b0;

        if (bus_io.start) begin
            state_d      = StCollect;
            buf_clear    = 1'b1;
            result_d     = '0;
            result_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (bus_io.inbyte_valid) begin
                        unique case (in_cls)
                            ClsDigit: begin
                                if (buf_count == CNT_W'(MAXDIG)) begin
                                    state_d = StSkip;
                                end else begin
                                    buf_push = 1'b1;
                                end
                            end
                            ClsDelim: begin
                                if (buf_count != '0) begin
                                    state_d = StCompute;
                                    acc_d   = '0;
                                    j_d     = buf_count;
                                    cerr_d  = 1'b0;
                                end
                            end
                            default: state_d = StSkip;
                        endcase
                    end
                end
                StSkip: begin
                    if (bus_io.inbyte_valid && (in_cls == ClsDelim)) begin
                        state_d      = StDone;
                        result_d     = '0;
                        result_err_d = 1'b1;
                    end
                end
                StCompute: begin
                    acc_d  = prod_w[W-1:0];
                    cerr_d = cerr_q | step_err;
                    j_d    = j_q - 1'b1;
                    if (j_q == CNT_W'(1)) begin
                        state_d      = StDone;
                        result_err_d = cerr_q | step_err;
                        result_d     = (cerr_q | step_err) ? '0 : prod_w[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            j_q          <= '0;
            cerr_q       <= 1'b0;
            result_q     <= '0;
            result_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            j_q          <= j_d;
            cerr_q       <= cerr_d;
            result_q     <= result_d;
            result_err_q <= result_err_d;
        end
    end

    assign bus_io.result       = result_q;
    assign bus_io.result_err   = result_err_q;
    assign bus_io.result_ready = ((state_q == StIdle) || (state_q == StDone)) && !bus_io.start;

endmodule

// File: tb/tb_infac_with_delims.sv
// Directed and randomized checks of infac_with_delims against a positional-sum model.
module tb_infac_with_delims;

    localparam int unsigned W = 22;
    typedef logic [7:0] byte_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    tests = 0;
    int    fails = 0;
    byte_t seq[$];

    infac_with_delims_if #(.W(W)) bus ();

    infac_with_delims #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fact(input int n);
        longint f = 1;
        for (int k = 2; k <= n; k++) f = f * k;
        return f;
    endfunction

    // Value = sum of digit * weight!, weights counting down from the digit count to 1.
    function automatic void model(input byte_t d1, input byte_t d2, output longint res,
                                  output bit err, output int term, output int ndig);
        int     digs[$];
        bit     skip;
        longint val;
        skip = 0; res = 0; err = 0; term = -1; ndig = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == d1 || seq[i] == d2) begin
                if (skip) begin
                    term = i; err = 1; return;
                end
                if (digs.size() > 0) begin
                    ndig = digs.size();
                    val  = 0;
                    for (int k = 0; k < ndig; k++) begin
                        if (digs[k] > ndig - k) err = 1;
                        val += longint'(digs[k]) * fact(ndig - k);
                    end
                    if (val > (longint'(1) << W) - 1) err = 1;
                    res  = err ? 0 : val;
                    term = i;
                    return;
                end
            end else if (seq[i] >= 8'h30 && seq[i] <= 8'h3B) begin
                if (!skip) begin
                    if (digs.size() == 12) skip = 1;
                    else digs.push_back(int'(seq[i]) - 48);
                end
            end else begin
                skip = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input byte_t b);
        bus.inbyte       = b;
        bus.inbyte_valid = 1'b1;
        tick();
        bus.inbyte_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        #1;
        check({tag, "/ready_in_start"}, bus.result_ready, 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "/err_cleared"}, bus.result_err, 0);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.result_ready !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic set_str(input string s);
        seq.delete();
        for (int i = 0; i < s.len(); i++) seq.push_back(byte_t'(s[i]));
    endtask

    task automatic run_seq(input string tag, input bit do_start);
        longint er;
        bit     ee;
        int     term, nd, cyc;
        model(bus.delim1byte, bus.delim2byte, er, ee, term, nd);
        if (term < 0) $fatal(1, "FAIL %s: stimulus has no terminator", tag);
        if (do_start) pulse_start(tag);
        for (int i = 0; i <= term; i++) send(seq[i]);
        wait_ready(cyc);
        check({tag, "/latency"}, cyc, nd);
        for (int i = term + 1; i < seq.size(); i++) send(seq[i]);
        check({tag, "/result"}, bus.result, er);
        check({tag, "/err"}, bus.result_err, ee);
        check({tag, "/ready"}, bus.result_ready, 1);
    endtask

    initial begin
        int    cyc, mode, n, lim, w, pick;
        byte_t dl[2];

        bus.start        = 1'b0;
        bus.inbyte       = 8'h00;
        bus.inbyte_valid = 1'b0;
        bus.delim1byte   = 8'h0D;
        bus.delim2byte   = 8'h0A;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset/ready", bus.result_ready, 1);
        check("reset/result", bus.result, 0);
        check("reset/err", bus.result_err, 0);

        // Bytes in IDLE are ignored.
        send(8'h35);
        send(8'h0D);
        check("idle/ready", bus.result_ready, 1);
        check("idle/result", bus.result, 0);

        set_str("54321"); seq.push_back(8'h0D);
        run_seq("conv719", 1);
        check("conv719/const", bus.result, 719);

        seq.delete(); seq.push_back(8'h0A);
        seq.push_back(8'h32); seq.push_back(8'h31);
        seq.push_back(8'h0D); seq.push_back(8'h0A);
        run_seq("multidelim", 1);
        check("multidelim/const", bus.result, 5);

        set_str("2"); seq.push_back(8'h0D);
        run_seq("digit_range", 1);
        check("digit_range/const_err", bus.result_err, 1);

        set_str("0"); seq.push_back(8'h0D);
        run_seq("zero", 1);
        check("zero/const_err", bus.result_err, 0);

        set_str("10000000000"); seq.push_back(8'h0D);
        run_seq("ovf11", 1);
        check("ovf11/const_err", bus.result_err, 1);

        set_str("1000000000"); seq.push_back(8'h0D);
        run_seq("fact10", 1);
        check("fact10/const", bus.result, 3628800);

        // Error must stay hidden until the terminator arrives.
        pulse_start("badchar");
        send(8'h31); send(8'h78); send(8'h30);
        check("badchar/err_early", bus.result_err, 0);
        check("badchar/ready_early", bus.result_ready, 0);
        send(8'h0D);
        check("badchar/ready", bus.result_ready, 1);
        check("badchar/err", bus.result_err, 1);

        set_str("0000000000000"); seq.push_back(8'h0D);
        run_seq("toomany", 1);
        check("toomany/const_err", bus.result_err, 1);

        set_str("000000000000"); seq.push_back(8'h0D);
        run_seq("maxdig", 1);

        pulse_start("rst_mid");
        send(8'h33); send(8'h32);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid/result", bus.result, 0);
        check("rst_mid/err", bus.result_err, 0);
        check("rst_mid/ready", bus.result_ready, 1);

        // Restart while the previous numeral is still being computed.
        pulse_start("restart");
        set_str("54321"); seq.push_back(8'h0D);
        for (int i = 0; i < seq.size(); i++) send(seq[i]);
        tick();
        check("restart/busy", bus.result_ready, 0);
        set_str("1"); seq.push_back(8'h0D);
        run_seq("restart", 1);
        check("restart/const", bus.result, 1);

        for (int it = 0; it < 40; it++) begin
            pick = $urandom_range(0, 2);
            case (pick)
                0:       begin dl[0] = 8'h0D; dl[1] = 8'h0A; end
                1:       begin dl[0] = 8'h2C; dl[1] = 8'h20; end
                default: begin dl[0] = 8'h0D; dl[1] = 8'h0D; end
            endcase
            bus.delim1byte = dl[0];
            bus.delim2byte = dl[1];
            seq.delete();
            if ($urandom_range(0, 3) == 0) seq.push_back(dl[$urandom_range(0, 1)]);
            mode = $urandom_range(0, 9);
            n    = (mode == 9) ? 13 : $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                w   = n - k;
                lim = (mode < 6) ? ((w > 11) ? 11 : w) : 11;
                seq.push_back(8'h30 + byte_t'($urandom_range(0, lim)));
            end
            if (mode == 8) seq.insert($urandom_range(0, seq.size()), 8'h78);
            seq.push_back(dl[$urandom_range(0, 1)]);
            if ($urandom_range(0, 1) == 1) seq.push_back(dl[$urandom_range(0, 1)]);
            run_seq($sformatf("rand%0d", it), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
